// File: rtl/ttl_serial_subtractor.sv
// Bit-serial LSB-first subtractor: D = A - B - Bin over WIDTH clocks.
// One full-subtractor cell plus a borrow flip-flop. Results and flags
// are held from one completion to the next.
module ttl_serial_subtractor #(
    parameter int WIDTH      = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Clear_bar,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Z,
    output logic             V
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_z;
    logic             r_v;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;
    logic             w_accept;
    logic             w_last;

    // Full-subtractor cell and next value of the result shift register
    always_comb begin
        w_d        = r_ra[0] ^ r_rb[0] ^ r_br;
        w_br_next  = (~r_ra[0] & r_rb[0]) | (~(r_ra[0] ^ r_rb[0]) & r_br);
        w_res_next = {w_d, r_res[WIDTH-1:1]};
        w_accept   = Start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_last     = (r_cnt == CW'(WIDTH - 1));
    end

    // Control FSM, serial datapath and held result registers
    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            r_state <= S_IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_z     <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_res <= w_res_next;
                    r_br  <= w_br_next;
                    r_ra  <= r_ra >> 1;
                    r_rb  <= r_rb >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Publish only the completed word; outputs never show partials
                        r_d     <= w_res_next;
                        r_bout  <= w_br_next;
                        r_z     <= (w_res_next == '0);
                        r_v     <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request (back-to-back in DONE)
                    if (w_accept) begin
                        r_ra    <= A;
                        r_rb    <= B;
                        r_br    <= Bin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_a_msb <= A[WIDTH-1];
                        r_b_msb <= B[WIDTH-1];
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Outputs carry the modelled package propagation delay
    assign #(DELAY_RISE, DELAY_FALL) Busy = (r_state == S_SHIFT);
    assign #(DELAY_RISE, DELAY_FALL) Done = (r_state == S_DONE);
    assign #(DELAY_RISE, DELAY_FALL) D    = r_d;
    assign #(DELAY_RISE, DELAY_FALL) Bout = r_bout;
    assign #(DELAY_RISE, DELAY_FALL) Z    = r_z;
    assign #(DELAY_RISE, DELAY_FALL) V    = r_v;

endmodule

// File: tb/tb_ttl_serial_subtractor.sv
// Directed bench for ttl_serial_subtractor (WIDTH=4).
module tb_ttl_serial_subtractor;

    localparam int W = 4;

    logic         Clk;
    logic         Clear_bar;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         Busy;
    logic         Done;
    logic [W-1:0] D;
    logic         Bout;
    logic         Z;
    logic         V;

    int n_checks;
    int n_errors;

    ttl_serial_subtractor #(.WIDTH(W), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
        .Clk       (Clk),
        .Clear_bar (Clear_bar),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .Busy      (Busy),
        .Done      (Done),
        .D         (D),
        .Bout      (Bout),
        .Z         (Z),
        .V         (V)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the first negedge after the accepting edge; stops at the Done cycle
    task automatic wait_done(output int nb, output bit seen);
        nb   = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (Busy === 1'b1) nb++;
            @(negedge Clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W-1:0] ed, input logic eb,
                          input logic ez, input logic ev);
        int          nb;
        bit          seen;
        logic [W-1:0] prev;
        @(negedge Clk);
        prev  = D;
        A     = a;
        B     = b;
        Bin   = bin;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk({tag, "_held_in_shift"}, D, prev);
        wait_done(nb, seen);
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_busy_cycles"}, nb, W);
        chk({tag, "_D"}, D, ed);
        chk({tag, "_Bout"}, Bout, eb);
        chk({tag, "_Z"}, Z, ez);
        chk({tag, "_V"}, V, ev);
        @(negedge Clk);
        chk({tag, "_done_pulse"}, Done, 0);
        chk({tag, "_D_hold"}, D, ed);
    endtask

    initial begin
        int  nb;
        int  gap;
        bit  seen;
        bit  stray;
        n_checks  = 0;
        n_errors  = 0;
        Clear_bar = 1'b0;
        Start     = 1'b0;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_D", D, 0);
        chk("rst_flags", {Bout, Z, V}, 0);
        Clear_bar = 1'b1;

        // Main function (V follows (A_msb!=B_msb)&(D_msb!=A_msb))
        run_op("9m3",   4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0, 1'b1);
        run_op("3m9",   4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1);
        run_op("5m5",   4'h5, 4'h5, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        run_op("0m0b",  4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
        run_op("7m8",   4'h7, 4'h8, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1);
        run_op("8m1",   4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1);
        run_op("FmFb",  4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);

        // Start held high, operands changed mid-shift, back-to-back in DONE
        @(negedge Clk);
        A     = 4'hC;
        B     = 4'h5;
        Bin   = 1'b1;
        Start = 1'b1;
        @(negedge Clk);               // after edge 0
        @(negedge Clk);               // after edge 1
        A   = 4'h2;                   // would be sampled at edge 2 if not ignored
        B   = 4'h3;
        Bin = 1'b0;
        wait_done(nb, seen);
        chk("hold_done_seen", seen, 1);
        chk("hold_busy_cycles", nb + 1, W);
        chk("hold_D", D, 4'h6);
        chk("hold_flags", {Bout, Z, V}, 3'b001);
        @(negedge Clk);               // DONE edge accepted Start
        Start = 1'b0;
        chk("b2b_busy", Busy, 1);
        gap = 1;
        wait_done(nb, seen);
        gap = gap + nb;
        chk("b2b_done_seen", seen, 1);
        chk("b2b_gap", gap, W + 1);
        chk("b2b_D", D, 4'hF);
        chk("b2b_flags", {Bout, Z, V}, 3'b100);
        @(negedge Clk);

        // Abort with reset at edge 2
        @(negedge Clk);
        A     = 4'h6;
        B     = 4'h2;
        Bin   = 1'b0;
        Start = 1'b1;
        @(negedge Clk);               // after edge 0
        Start = 1'b0;
        @(negedge Clk);               // after edge 1
        Clear_bar = 1'b0;
        @(negedge Clk);               // after edge 2
        Clear_bar = 1'b1;
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        chk("abort_D", D, 0);
        chk("abort_flags", {Bout, Z, V}, 0);
        stray = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (Done !== 1'b0 || Busy !== 1'b0) stray = 1'b1;
            @(negedge Clk);
        end
        chk("abort_no_done", stray, 0);
        run_op("after", 4'h6, 4'h2, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
